medidor_nivel_banda: RTL and testbench

//  Per-band level meter feeding the equalizer display register. Takes signed band-filtered

---
 rtl/medidor_nivel_banda_if.sv | 32 +++
 rtl/medidor_nivel_banda.sv | 188 ++++++++++++++++++
 tb/tb_medidor_nivel_banda.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/medidor_nivel_banda_if.sv
// Sample/level bus between a band-filter source and the level meter.
// The master side produces samples and receives the displayed level;
// the slave side is the meter itself.
interface medidor_nivel_banda_if #(
    parameter int DATA_W = 16,
    parameter int width  = 4
);
    logic                     habilitar;
    logic                     muestra_valida;
    logic signed [DATA_W-1:0] muestra;
    logic [width-1:0]         nivel;
    logic                     nivel_valido;
    logic                     recorte;

    modport master (
        output habilitar,
        output muestra_valida,
        output muestra,
        input  nivel,
        input  nivel_valido,
        input  recorte
    );

    modport slave (
        input  habilitar,
        input  muestra_valida,
        input  muestra,
        output nivel,
        output nivel_valido,
        output recorte
    );
endinterface

// File: rtl/medidor_nivel_banda.sv
// Per-band level meter for the equalizer display.
// Tracks the peak |sample| over WIN_LEN accepted samples, then pushes the
// window result through a three-stage pipeline (capture, quantize, publish)
// that produces a width-bit level with decay-style peak hold, a clip flag and
// a one-cycle nivel_valido pulse used as the display register enable.
module medidor_nivel_banda #(
    parameter int DATA_W  = 16,
    parameter int width   = 4,
    parameter int WIN_LEN = 1024,
    parameter int DECAY   = 1
) (
    input  logic                  clk44kHz,
    input  logic                  reset,
    medidor_nivel_banda_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    // Right shift that maps the top magnitude bits onto the level range.
    localparam int SHIFT = DATA_W - 1 - width;

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [DATA_W-1:0] MAG_ONE    = DATA_W'(1);
    // Anything at or above 2^(DATA_W-1)-1 counts as near full scale.
    localparam logic [DATA_W-1:0] CLIP_TH    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] LEVEL_CEIL = {{(DATA_W-width){1'b0}}, {width{1'b1}}};
    localparam logic [width-1:0]  LEVEL_MAX  = {width{1'b1}};
    // A decay step at least as large as the level range always drops to 0.
    localparam bit                FULL_DROP  = (DECAY >= (1 << width));
    localparam logic [width-1:0]  DECAY_STEP = FULL_DROP ? LEVEL_MAX : width'(DECAY);

    // ------------------------------------------------------------------
    // Sample front end
    // ------------------------------------------------------------------
    logic              accept;
    logic [DATA_W-1:0] rawBits;
    logic [DATA_W-1:0] mag;
    logic              isClip;
    logic              closing;

    // Window state
    logic [CNT_W-1:0]  winCnt;
    logic [DATA_W-1:0] peakMag;
    logic              clipAcc;
    logic [DATA_W-1:0] peakNext;

    // Capture stage
    logic              capValid;
    logic [DATA_W-1:0] snapPeak;
    logic              clipSnap;

    // Quantize stage
    logic              quantValid;
    logic [width-1:0]  quantLevel;
    logic              quantClip;
    logic [DATA_W-1:0] shifted;
    logic [width-1:0]  quantNext;

    // Publish stage
    logic              pubValid;
    logic [width-1:0]  heldLevel;
    logic              clipOut;
    logic [width-1:0]  decayed;
    logic [width-1:0]  heldNext;

    assign accept  = bus.habilitar & bus.muestra_valida;
    assign rawBits = bus.muestra;

    // Magnitude, clip detection, running maximum and window-close detection.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
        mag      = rawBits;
        isClip   = 1'b0;
        peakNext = peakMag;
        closing  = 1'b0;

        // Two's complement negate; the most negative code maps to 2^(DATA_W-1) as unsigned.
        if (rawBits[DATA_W-1]) begin
            mag = ~rawBits + MAG_ONE;
        end

        isClip = (mag >= CLIP_TH);

        if (mag > peakMag) begin
            peakNext = mag;
        end

        closing = accept && (winCnt == LAST_CNT);
    end

    // Window accumulation: sample count, peak magnitude and clip flag.
    always_ff @(posedge clk44kHz or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            winCnt  <= '0;
            peakMag <= '0;
            clipAcc <= 1'b0;
        end else if (accept) begin
            if (winCnt == LAST_CNT) begin
                // The closing sample is folded into the snapshot; the next sample opens a fresh window.
                winCnt  <= '0;
                peakMag <= '0;
                clipAcc <= 1'b0;
            end else begin
                winCnt  <= winCnt + CNT_ONE;
                peakMag <= peakNext;
                clipAcc <= clipAcc | isClip;
            end
        end
    end

    // Capture stage: freeze the finished window so accumulation can restart immediately.
    always_ff @(posedge clk44kHz or negedge reset) begin
        // NOTE: every pipeline register, data included, is reset so no pending result survives a reset.
        if (!reset) begin
            capValid <= 1'b0;
            snapPeak <= '0;
            clipSnap <= 1'b0;
        end else begin
            capValid <= closing;
            if (closing) begin
                snapPeak <= peakNext;
                clipSnap <= clipAcc | isClip;
            end
        end
    end

    // Level quantization: keep the top bits, saturating the single overflow code (-full scale).
    always_comb begin
        shifted   = snapPeak >> SHIFT;
        quantNext = shifted[width-1:0];
        if (shifted > LEVEL_CEIL) begin
            quantNext = LEVEL_MAX;
        end
    end

    // Quantize stage.
    always_ff @(posedge clk44kHz or negedge reset) begin
        if (!reset) begin
            quantValid <= 1'b0;
            quantLevel <= '0;
            quantClip  <= 1'b0;
        end else begin
            quantValid <= capValid;
            if (capValid) begin
                quantLevel <= quantNext;
                quantClip  <= clipSnap;
            end
        end
    end

    // Peak hold: the level may fall by at most DECAY per window; DECAY=0 shows the raw window peak.
    always_comb begin
        decayed  = '0;
        heldNext = quantLevel;
        if (DECAY != 0) begin
            if (!FULL_DROP && (heldLevel > DECAY_STEP)) begin
                decayed = heldLevel - DECAY_STEP;
            end
            if (decayed > quantLevel) begin
                heldNext = decayed;
            end
        end
    end

    // Publish stage: the held level register is the displayed level itself.
    always_ff @(posedge clk44kHz or negedge reset) begin
        if (!reset) begin
            pubValid  <= 1'b0;
            heldLevel <= '0;
            clipOut   <= 1'b0;
        end else begin
            pubValid <= quantValid;
            if (quantValid) begin
                heldLevel <= heldNext;
                clipOut   <= quantClip;
            end
        end
    end

    assign bus.nivel        = heldLevel;
    assign bus.nivel_valido = pubValid;
    assign bus.recorte      = clipOut;

endmodule

// File: tb/tb_medidor_nivel_banda.sv
// Directed bench for medidor_nivel_banda.
// Instance A: WIN_LEN=4 (reset, basic window, decay, clip, gaps).
// Instance B: WIN_LEN=2 (back-to-back windows every 2 cycles).
module tb_medidor_nivel_banda;

    logic clk44kHz = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lastCyc  = 0;
    int closeCyc = 0;
    int closeB[4];
    int decayExp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 0};

    typedef struct {
        logic [3:0] lvl;
        logic       clip;
        int         at;
    } pulse_t;

    pulse_t qA[$];
    pulse_t qB[$];

    medidor_nivel_banda_if #(.DATA_W(16), .width(4)) busA ();
    medidor_nivel_banda_if #(.DATA_W(16), .width(4)) busB ();

    medidor_nivel_banda #(.DATA_W(16), .width(4), .WIN_LEN(4), .DECAY(1)) dutA (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .bus      (busA.slave)
    );

    medidor_nivel_banda #(.DATA_W(16), .width(4), .WIN_LEN(2), .DECAY(1)) dutB (
        .clk44kHz (clk44kHz),
        .reset    (reset),
        .bus      (busB.slave)
    );

    initial forever #5 clk44kHz = ~clk44kHz;

    always @(posedge clk44kHz) cyc <= cyc + 1;

    // Record every level pulse with the cycle it was seen in.
    always @(negedge clk44kHz) begin
        if (busA.nivel_valido === 1'b1) qA.push_back('{busA.nivel, busA.recorte, cyc});
        if (busB.nivel_valido === 1'b1) qB.push_back('{busB.nivel, busB.recorte, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic driveA(input bit h, input bit v, input int s);
        @(negedge clk44kHz);
        busA.habilitar      = h;
        busA.muestra_valida = v;
        busA.muestra        = 16'(s);
        lastCyc             = cyc;
    endtask

    task automatic sendWindow(input int s0, input int s1, input int s2, input int s3);
        driveA(1'b1, 1'b1, s0);
        driveA(1'b1, 1'b1, s1);
        driveA(1'b1, 1'b1, s2);
        driveA(1'b1, 1'b1, s3);
        closeCyc = lastCyc;
        driveA(1'b1, 1'b0, 0);
    endtask

    // Wait (bounded) for the next pulse on A and check level, clip, latency and pulse width.
    task automatic waitPulse(input string tag, input int expLvl, input int expClip);
        pulse_t p;
        for (int i = 0; i < 12 && qA.size() == 0; i++) begin
            @(negedge clk44kHz);
            #1;
        end
        if (qA.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            p = qA.pop_front();
            check({tag, "_nivel"}, 32'(p.lvl), expLvl);
            check({tag, "_recorte"}, 32'(p.clip), expClip);
            check({tag, "_latency"}, p.at, closeCyc + 3);
            repeat (2) @(negedge clk44kHz);
            #1;
            check({tag, "_width"}, qA.size(), 0);
        end
    endtask

    initial begin
        busA.habilitar = 1'b0; busA.muestra_valida = 1'b0; busA.muestra = '0;
        busB.habilitar = 1'b0; busB.muestra_valida = 1'b0; busB.muestra = '0;
        reset = 1'b0;

        // Reset state
        repeat (3) @(negedge clk44kHz);
        #1;
        check("rst_nivel",   32'(busA.nivel), 0);
        check("rst_valido",  32'(busA.nivel_valido), 0);
        check("rst_recorte", 32'(busA.recorte), 0);
        check("rst_nivelB",  32'(busB.nivel), 0);
        @(negedge clk44kHz);
        reset = 1'b1;

        // Basic window: peak 16384 -> 8
        sendWindow(100, -16384, 2048, 0);
        waitPulse("basic", 8, 0);

        // Reset while a clipped result sits in the pipeline: outputs clear at once, result discarded
        sendWindow(-32768, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("rstPipe_nivel",   32'(busA.nivel), 0);
        check("rstPipe_valido",  32'(busA.nivel_valido), 0);
        check("rstPipe_recorte", 32'(busA.recorte), 0);
        repeat (2) @(negedge clk44kHz);
        reset = 1'b1;
        repeat (6) @(negedge clk44kHz);
        #1;
        check("rstPipe_discard", qA.size(), 0);
        check("rstPipe_hold",    32'(busA.nivel), 0);

        // Reset mid-window: counter, peak and clip must restart
        driveA(1'b1, 1'b1, 32767);
        driveA(1'b1, 1'b1, 32767);
        driveA(1'b1, 1'b1, 32767);
        driveA(1'b1, 1'b0, 0);
        #2 reset = 1'b0;
        @(negedge clk44kHz);
        reset = 1'b1;
        driveA(1'b1, 1'b1, 4096);
        driveA(1'b1, 1'b1, 4096);
        driveA(1'b1, 1'b1, 4096);
        repeat (4) driveA(1'b1, 1'b0, 0);
        #1;
        check("rstWin_noEarlyPulse", qA.size(), 0);
        driveA(1'b1, 1'b1, 4096);
        closeCyc = lastCyc;
        driveA(1'b1, 1'b0, 0);
        waitPulse("rstWin", 2, 0);

        // Decay: 8 then zeros, with a q=2 window landing when the level is 5
        sendWindow(0, 16384, 0, 0);
        waitPulse("decayLoad", 8, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) sendWindow(0, 4096, 0, 0);
            else        sendWindow(0, 0, 0, 0);
            waitPulse($sformatf("decay%0d", i), decayExp[i], 0);
        end

        // Clip threshold
        sendWindow(0, -32768, 0, 0);
        waitPulse("clipNeg", 15, 1);
        sendWindow(0, 0, 32767, 0);
        waitPulse("clipPos", 15, 1);
        sendWindow(32766, 0, 0, 0);
        waitPulse("clipBelow", 15, 0);
        sendWindow(0, 0, 0, 0);
        waitPulse("clipZeros", 14, 0);

        // Strobe every 3rd cycle; full-scale values on unaccepted cycles must be ignored
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (2) driveA(1'b1, 1'b0, -32768);
            driveA(1'b1, 1'b1, (i == 1) ? 8192 : 0);
        end
        closeCyc = lastCyc;
        driveA(1'b1, 1'b0, 0);
        waitPulse("gapStrobe", 13, 0);

        // habilitar=0 gaps; habilitar also low while the result is in the pipeline
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (2) driveA(1'b0, 1'b1, -32768);
            driveA(1'b1, 1'b1, (i == 2) ? 16384 : 0);
        end
        closeCyc = lastCyc;
        driveA(1'b0, 1'b0, 0);
        waitPulse("gapHab", 12, 0);
        driveA(1'b1, 1'b0, 0);

        // Back-to-back windows of 2 on instance B
        for (int i = 0; i < 8; i++) begin
            @(negedge clk44kHz);
            busB.habilitar      = 1'b1;
            busB.muestra_valida = 1'b1;
            busB.muestra        = ((i % 4) == 0) ? 16'sd16384 : 16'sd0;
            if ((i % 2) == 1) closeB[i / 2] = cyc;
        end
        @(negedge clk44kHz);
        busB.muestra_valida = 1'b0;
        repeat (6) @(negedge clk44kHz);
        #1;
        check("b2b_count", qB.size(), 4);
        for (int j = 0; j < 4 && qB.size() > 0; j++) begin
            pulse_t p;
            p = qB.pop_front();
            check($sformatf("b2b%0d_nivel", j),   32'(p.lvl), ((j % 2) == 0) ? 8 : 7);
            check($sformatf("b2b%0d_latency", j), p.at, closeB[j] + 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
